// File: rtl/unsigned_divider.sv
// unsigned_divider: sequential 4-bit by 2-bit unsigned restoring divider.
// One quotient bit is resolved per clock, MSB first, so a result takes four
// CALC cycles after the start is accepted. Results are held on the LED
// outputs until the next result write or reset.
//
// Optional feature macro: UNSIGNED_DIVIDER_DIV_ZERO_EN
//   defined   - a start with in2==0 is answered immediately with done,
//               div_by_zero=1 and zeroed results; no iteration is run.
//   undefined - div_by_zero is tied 0 and divisor 0 runs the normal
//               iteration (quotient 4'b1111, remainder in1[1:0]).
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | iterating, one quotient bit per cycle, counter 3 down to 0
module unsigned_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] in1,
    input  logic [1:0] in2,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient_led,
    output logic [1:0] remainder_led,
    output logic       div_by_zero
);

    typedef enum logic {IDLE, CALC} state_t;

    state_t     state_q, state_d;
    logic [3:0] dividend_q, dividend_d;
    logic [1:0] divisor_q, divisor_d;
    logic [2:0] rem_q, rem_d;
    logic [3:0] quot_q, quot_d;
    logic [1:0] cnt_q, cnt_d;
    logic       busy_d, done_d;
    logic [3:0] quotient_led_d;
    logic [1:0] remainder_led_d;

    logic [2:0] r_shift;
    logic [2:0] r_sub;
    logic [2:0] div_ext;
    logic       q_bit;
    logic       zero_reject;

`ifdef UNSIGNED_DIVIDER_DIV_ZERO_EN
    assign zero_reject = (in2 == 2'b00);
`else
    assign zero_reject = 1'b0;
`endif

    // Next-state and datapath: one restoring step per CALC cycle.
    always_comb begin
        state_d         = state_q;
        dividend_d      = dividend_q;
        divisor_d       = divisor_q;
        rem_d           = rem_q;
        quot_d          = quot_q;
        cnt_d           = cnt_q;
        busy_d          = busy;
        done_d          = 1'b0;
        quotient_led_d  = quotient_led;
        remainder_led_d = remainder_led;

        div_ext = {1'b0, divisor_q};
        r_shift = {rem_q[1:0], dividend_q[cnt_q]};
        q_bit   = (r_shift >= div_ext);
        r_sub   = q_bit ? (r_shift - div_ext) : r_shift;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (zero_reject) begin
                        done_d          = 1'b1;
                        quotient_led_d  = 4'd0;
                        remainder_led_d = 2'd0;
                    end else begin
                        dividend_d = in1;
                        divisor_d  = in2;
                        rem_d      = 3'd0;
                        quot_d     = 4'd0;
                        cnt_d      = 2'd3;
                        busy_d     = 1'b1;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                rem_d  = r_sub;
                quot_d = {quot_q[2:0], q_bit};
                cnt_d  = cnt_q - 2'd1;
                if (cnt_q == 2'd0) begin
                    quotient_led_d  = {quot_q[2:0], q_bit};
                    // The remainder is below the divisor, so bit 2 is always 0.
                    remainder_led_d = r_sub[1:0];
                    done_d          = 1'b1;
                    busy_d          = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            dividend_q    <= 4'd0;
            divisor_q     <= 2'd0;
            rem_q         <= 3'd0;
            quot_q        <= 4'd0;
            cnt_q         <= 2'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            quotient_led  <= 4'd0;
            remainder_led <= 2'd0;
        end else begin
            state_q       <= state_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            rem_q         <= rem_d;
            quot_q        <= quot_d;
            cnt_q         <= cnt_d;
            busy          <= busy_d;
            done          <= done_d;
            quotient_led  <= quotient_led_d;
            remainder_led <= remainder_led_d;
        end
    end

`ifdef UNSIGNED_DIVIDER_DIV_ZERO_EN
    // Flag is refreshed on every accepted start and otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_by_zero <= 1'b0;
        end else if (state_q == IDLE && start) begin
            div_by_zero <= zero_reject;
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_unsigned_divider.sv
// Self-checking bench for unsigned_divider: directed scenarios plus an
// exhaustive sweep and random operations against an arithmetic model.
module tb_unsigned_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] in1;
    logic [1:0] in2;
    logic       busy;
    logic       done;
    logic [3:0] quotient_led;
    logic [1:0] remainder_led;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

`ifdef UNSIGNED_DIVIDER_DIV_ZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    unsigned_divider dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in1          (in1),
        .in2          (in2),
        .busy         (busy),
        .done         (done),
        .quotient_led (quotient_led),
        .remainder_led(remainder_led),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; divisor 0 gives all-ones quotient
    // and the low dividend bits as remainder when the iteration runs.
    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? 15 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? (a % 4) : a % b;
    endfunction

    // One complete operation with cycle-by-cycle handshake checks.
    task automatic run_op(input int a, input int b);
        @(negedge clk);
        in1 = 4'(a); in2 = 2'(b); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (DZ_EN && b == 0) begin
            chk("dz_done", done, 1);
            chk("dz_flag", div_by_zero, 1);
            chk("dz_busy", busy, 0);
            chk("dz_quot", quotient_led, 0);
            chk("dz_rem", remainder_led, 0);
            @(negedge clk);
            chk("dz_done_drop", done, 0);
            chk("dz_flag_hold", div_by_zero, 1);
            chk("dz_busy_idle", busy, 0);
            return;
        end
        chk("busy_e0", busy, 1);
        chk("done_e0", done, 0);
        chk("dz_clear", div_by_zero, 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("busy_calc", busy, 1);
            chk("done_calc", done, 0);
        end
        @(negedge clk);
        chk("done_e4", done, 1);
        chk("busy_e4", busy, 0);
        chk("quot", quotient_led, 8'(ref_q(a, b)));
        chk("rem", remainder_led, 8'(ref_r(a, b)));
        chk("dz_flag0", div_by_zero, 0);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("quot_hold", quotient_led, 8'(ref_q(a, b)));
    endtask

    initial begin
        int a, b;
        rst = 1'b1; start = 1'b0; in1 = 4'd0; in2 = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient_led, 0);
        chk("rst_rem", remainder_led, 0);
        chk("rst_dz", div_by_zero, 0);
        rst = 1'b0;

        // Basic 13/3
        run_op(13, 3);

        // Exhaustive sweep over non-zero divisors
        for (int x = 0; x < 16; x++)
            for (int y = 1; y < 4; y++)
                run_op(x, y);

        // Start during busy is ignored
        @(negedge clk);
        in1 = 4'd15; in2 = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy0", busy, 1);
        @(negedge clk);
        in1 = 4'd2; in2 = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy2", busy, 1);
        chk("ign_done2", done, 0);
        @(negedge clk);
        chk("ign_done3", done, 0);
        @(negedge clk);
        chk("ign_done4", done, 1);
        chk("ign_quot", quotient_led, 15);
        chk("ign_rem", remainder_led, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ign_no_extra_done", done, 0);
            chk("ign_no_busy", busy, 0);
        end

        // Reset during CALC aborts without done
        @(negedge clk);
        in1 = 4'd2; in2 = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quot", quotient_led, 0);
        chk("abort_rem", remainder_led, 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        run_op(9, 2);

        // Divide by zero (either build)
        run_op(6, 0);
        run_op(5, 1);

        // Start held high across two operations
        @(negedge clk);
        in1 = 4'd7; in2 = 2'd2; start = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            chk("held_done", done, (c == 4 || c == 9) ? 8'd1 : 8'd0);
            chk("held_busy", busy, (c != 4 && c != 9) ? 8'd1 : 8'd0);
            if (c == 4 || c == 9) begin
                chk("held_quot", quotient_led, 3);
                chk("held_rem", remainder_led, 1);
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("held_end_done", done, 0);
        chk("held_end_busy", busy, 0);

        // Random operations including divisor 0
        for (int k = 0; k < 40; k++) begin
            a = int'($urandom_range(15));
            b = int'($urandom_range(3));
            run_op(a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
